vram_arbiter: RTL and testbench

// - Shares the single-port 8 KB video RAM between the video fetch pipeline and the Z80 CPU bus.
// - Sits between the video fetch pipeline (address/data to the HDMI path) and the CPU memory decoder.
// - Drives one synchronous BRAM port, which has 1-cycle read latency.
// - Video normally wins arbitration; a starvation guard bounds CPU stall.

---
 rtl/vram_arbiter.sv | 121 ++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one synchronous BRAM port between video fetch and the Z80 bus.
// Define VRAM_ARB_STATS_EN to add the stat_cpu_stall counter output.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_wait,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, DATA} state_t;

  localparam logic [3:0] STARVE_THRESH = 4'(STARVE_LIMIT);

  state_t     state;
  logic       owner_cpu;
  logic       owner_we;
  logic [3:0] starve_cnt;

  logic slot_open;
  logic cpu_wins;
  logic grant_cpu;
  logic grant_vid;
  logic grant_any;

  // Grants are only taken at edges leaving IDLE or DATA; ACC is always followed by DATA.
  always_comb begin
    slot_open = (state != ACC);
    cpu_wins  = cpu_req && ((starve_cnt >= STARVE_THRESH) || !vid_req);
    grant_cpu = slot_open && cpu_wins;
    grant_vid = slot_open && vid_req && !cpu_wins;
    grant_any = grant_cpu || grant_vid;
  end

  assign cpu_wait = cpu_req & ~cpu_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_cpu  <= 1'b0;
      owner_we   <= 1'b0;
      starve_cnt <= '0;
      vid_ack    <= 1'b0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      vid_ack <= grant_vid;
      ram_ce  <= grant_any;
      ram_we  <= grant_cpu && cpu_we;
      if (grant_any) begin
        owner_cpu <= grant_cpu;
        owner_we  <= grant_cpu && cpu_we;
        ram_addr  <= grant_cpu ? cpu_addr : vid_addr;
        ram_wdata <= grant_cpu ? cpu_wdata : '0;
      end

      // Response of the access in flight; uses the owner latched at its grant.
      vid_valid <= (state == DATA) && !owner_cpu;
      cpu_done  <= (state == DATA) && owner_cpu;
      if (state == DATA) begin
        if (owner_cpu) begin
          cpu_rdata <= owner_we ? '0 : ram_rdata;
        end else begin
          vid_data <= ram_rdata;
        end
      end

      case (state)
        IDLE:    if (grant_any) state <= ACC;
        ACC:     state <= DATA;
        DATA:    state <= grant_any ? ACC : IDLE;
        default: state <= IDLE;
      endcase

      if (!cpu_req || grant_cpu) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_stall <= '0;
    end else if (cpu_wait && (stat_cpu_stall != 16'hFFFF)) begin
      stat_cpu_stall <= stat_cpu_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a per-cycle timeline model of grants and responses,
// checked every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int SL = 4;
  localparam int MEM_N = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;
  logic          cpu_wait;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   stat_cpu_stall;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk),
    .reset(reset),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_ack(vid_ack),
    .vid_valid(vid_valid),
    .vid_data(vid_data),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done),
    .cpu_wait(cpu_wait),
    .ram_ce(ram_ce),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stat_cpu_stall(stat_cpu_stall)
`endif
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
  endtask

  function automatic logic [7:0] init_byte(input int a);
    logic [7:0] b;
    b = 8'(a * 37 + 11);
    if (a == 256) b = 8'hA5;
    return b;
  endfunction

  // Synchronous single-port RAM with 1-cycle read latency.
  logic [DW-1:0] mem [0:MEM_N-1];
  initial begin
    for (int i = 0; i < MEM_N; i++) mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (ram_ce === 1'b1) begin
        if (ram_we) mem[ram_addr] = ram_wdata;
        else ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Reference model: each grant books its ack/ce slot and its response slot two cycles later.
  logic          e_vack   [8];
  logic          e_vvalid [8];
  logic          e_cdone  [8];
  logic          e_ce     [8];
  logic          e_we     [8];
  logic [AW-1:0] e_addr   [8];
  logic [DW-1:0] e_wdata  [8];
  logic [DW-1:0] e_vdata  [8];
  logic [DW-1:0] e_crdata [8];
  logic [DW-1:0] ref_mem  [0:MEM_N-1];
  int free_at = 0;
  int starve = 0;
  int stall = 0;
  int m_nxt, m_sa, m_sd;
  bit m_cw, m_vw;

  task automatic clear_slot(input int s);
    e_vack[s] = 1'b0; e_vvalid[s] = 1'b0; e_cdone[s] = 1'b0;
    e_ce[s] = 1'b0; e_we[s] = 1'b0; e_addr[s] = '0; e_wdata[s] = '0;
    e_vdata[s] = '0; e_crdata[s] = '0;
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_byte(i);
    for (int s = 0; s < 8; s++) clear_slot(s);
    forever begin
      @(posedge clk);
      m_nxt = cyc + 1;
      if (reset) begin
        for (int s = 0; s < 8; s++) clear_slot(s);
        starve = 0;
        stall = 0;
        free_at = m_nxt;
      end else begin
        if (cpu_req && !e_cdone[cyc % 8] && stall < 65535) stall++;
        clear_slot(cyc % 8);
        m_cw = 1'b0;
        m_vw = 1'b0;
        if (m_nxt >= free_at) begin
          m_cw = cpu_req && (starve >= SL || !vid_req);
          m_vw = vid_req && !m_cw;
        end
        if (m_cw || m_vw) begin
          m_sa = m_nxt % 8;
          m_sd = (m_nxt + 2) % 8;
          e_ce[m_sa] = 1'b1;
          e_we[m_sa] = m_cw && cpu_we;
          e_addr[m_sa] = m_cw ? cpu_addr : vid_addr;
          e_wdata[m_sa] = cpu_wdata;
          e_vack[m_sa] = m_vw;
          if (m_vw) begin
            e_vvalid[m_sd] = 1'b1;
            e_vdata[m_sd] = ref_mem[vid_addr];
          end else begin
            e_cdone[m_sd] = 1'b1;
            e_crdata[m_sd] = cpu_we ? '0 : ref_mem[cpu_addr];
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
          end
          free_at = m_nxt + 2;
        end
        if (!cpu_req || m_cw) starve = 0;
        else if (starve < 15) starve++;
      end
      cyc = m_nxt;
    end
  end

  int chk_s;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk_s = cyc % 8;
        check("vid_ack", vid_ack, e_vack[chk_s]);
        check("vid_valid", vid_valid, e_vvalid[chk_s]);
        check("cpu_done", cpu_done, e_cdone[chk_s]);
        check("ram_ce", ram_ce, e_ce[chk_s]);
        check("cpu_wait", cpu_wait, cpu_req & ~e_cdone[chk_s]);
        if (e_ce[chk_s]) begin
          check("ram_we", ram_we, e_we[chk_s]);
          check("ram_addr", ram_addr, e_addr[chk_s]);
          if (e_we[chk_s]) check("ram_wdata", ram_wdata, e_wdata[chk_s]);
        end
        if (e_vvalid[chk_s]) check("vid_data", vid_data, e_vdata[chk_s]);
        if (e_cdone[chk_s]) check("cpu_rdata", cpu_rdata, e_crdata[chk_s]);
`ifdef VRAM_ARB_STATS_EN
        check("stat_cpu_stall", stat_cpu_stall, stall);
`endif
        if (vid_valid === 1'b1) $display("txn cyc=%0d video read data=%0h", cyc, vid_data);
        if (cpu_done === 1'b1) $display("txn cyc=%0d cpu done rdata=%0h", cyc, cpu_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int acks, vals, last_val, ce_adj, stat0;
  bit prev_ce, pend;

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_vid_ack", vid_ack, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_ram_ce", ram_ce, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_vid_data", vid_data, 0);
    reset = 1'b0;
    tick();

    // Lone video read of 0x100
    vid_req = 1'b1; vid_addr = 13'h0100;
    tick();
    check("t1_ack", vid_ack, 1);
    check("t1_ce", ram_ce, 1);
    check("t1_addr", ram_addr, 13'h0100);
    tick();
    vid_req = 1'b0;
    check("t1_early_valid", vid_valid, 0);
    tick();
    check("t1_valid", vid_valid, 1);
    check("t1_data", vid_data, 8'hA5);
    tick();
    check("t1_pulse_end", vid_valid, 0);
    idle(4);

    // CPU write 0x3C to 0x1FFF, request held until done
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'h3C;
    #1;
    check("t2_wait_start", cpu_wait, 1);
    tick();
    check("t2_ram_we", ram_we, 1);
    check("t2_ram_addr", ram_addr, 13'h1FFF);
    check("t2_ram_wdata", ram_wdata, 8'h3C);
    tick();
    check("t2_wait_mid", cpu_wait, 1);
    tick();
    check("t2_done", cpu_done, 1);
    check("t2_wait_end", cpu_wait, 0);
    cpu_req = 1'b0;
    idle(6);

    // CPU read back 0x1FFF
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    check("t3_ram_we", ram_we, 0);
    tick();
    check("t3_wait", cpu_wait, 1);
    tick();
    check("t3_done", cpu_done, 1);
    check("t3_rdata", cpu_rdata, 8'h3C);
    cpu_req = 1'b0;
    idle(6);

    // Contention: video always requesting, CPU read of 0x100 wins after 4 stalled cycles
    vid_req = 1'b1; vid_addr = 13'h0040;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
`ifdef VRAM_ARB_STATS_EN
    stat0 = int'(stat_cpu_stall);
`endif
    acks = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) begin
        if (vid_ack === 1'b1) acks++;
        if (cpu_done === 1'b1) check("t4_early_done", cpu_done, 0);
      end
      if (k == 5) check("t4_cpu_addr", ram_addr, 13'h0100);
    end
    check("t4_vid_acks_before", acks, 2);
    check("t4_done", cpu_done, 1);
    check("t4_rdata", cpu_rdata, 8'hA5);
    check("t4_video_resumes", vid_ack, 1);
`ifdef VRAM_ARB_STATS_EN
    check("t4_stall_count", int'(stat_cpu_stall) - stat0, 7);
`endif
    cpu_req = 1'b0;
    vid_req = 1'b0;
    idle(6);

    // Back-to-back video: four requests, address stepped after each ack
    vid_req = 1'b1; vid_addr = 13'h0200;
    acks = 0; vals = 0; last_val = 0; ce_adj = 0; prev_ce = 1'b0; pend = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (pend) begin
        if (acks >= 4) vid_req = 1'b0;
        else vid_addr = vid_addr + 13'd1;
        pend = 1'b0;
      end
      if (vid_ack === 1'b1) begin
        acks++;
        pend = 1'b1;
      end
      if (vid_valid === 1'b1) begin
        if (vals > 0) check("t5_valid_gap", k - last_val, 2);
        last_val = k;
        vals++;
      end
      if (ram_ce === 1'b1 && prev_ce) ce_adj++;
      prev_ce = (ram_ce === 1'b1);
    end
    check("t5_acks", acks, 4);
    check("t5_valids", vals, 4);
    check("t5_ce_adjacent", ce_adj, 0);
    idle(3);

    // Reset during DATA drops the pending response
    vid_req = 1'b1; vid_addr = 13'h0100;
    tick();
    check("t6_ack", vid_ack, 1);
    tick();
    vid_req = 1'b0;
    reset = 1'b1;
    tick();
    check("t6_no_valid", vid_valid, 0);
    check("t6_ack_zero", vid_ack, 0);
    check("t6_ce_zero", ram_ce, 0);
    check("t6_data_zero", vid_data, 0);
    check("t6_addr_zero", ram_addr, 0);
    reset = 1'b0;
    tick();
    check("t6_still_no_valid", vid_valid, 0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
